// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for the Common Data Bus.
// Finished functional units / reservation stations hold Req with their tag,
// result and destination register. One winner per cycle is broadcast on
// registered CDB outputs. The one-cycle Grant pulse is the winner's acknowledge.
module cdb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [N_REQ-1:0]          Req,
  input  logic [N_REQ*TAG_W-1:0]    Tag_in,
  input  logic [N_REQ*DATA_W-1:0]   Value_in,
  input  logic [N_REQ*3-1:0]        Rdst_in,
  input  logic                      Stall,
  output logic [N_REQ-1:0]          Grant,
  output logic                      Cdb_valid,
  output logic [TAG_W-1:0]          Cdb_tag,
  output logic [DATA_W-1:0]         Cdb_value,
  output logic [2:0]                Cdb_rdst,
  output logic                      Tag_error
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]  grant_q,     grant_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q,   cdb_tag_d;
  logic [DATA_W-1:0] cdb_value_q, cdb_value_d;
  logic [2:0]        cdb_rdst_q,  cdb_rdst_d;
  logic              tag_error_q, tag_error_d;
  logic [PTR_W-1:0]  ptr_q,       ptr_d;

  logic [N_REQ-1:0]  eligible;
  logic              found;
  logic [PTR_W-1:0]  win;

  // Eligibility: requesting, non-zero tag, and not the station acknowledged last
  // edge (it is still holding Req for one cycle before it can drop it).
  always_comb begin
    eligible    = '0;
    tag_error_d = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = Req[i] && (Tag_in[i*TAG_W +: TAG_W] != '0) && !grant_q[i];
      if (Req[i] && (Tag_in[i*TAG_W +: TAG_W] == '0))
        tag_error_d = 1'b1;
    end
  end

  // Round-robin scan starting at ptr_q, wrapping modulo N_REQ.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ)
        idx = idx - N_REQ;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
  end

  // Next broadcast: load the winner's fields, otherwise hold the bus payload
  // (it is qualified by Cdb_valid) and leave the pointer alone.
  always_comb begin
    grant_d     = '0;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_value_d = cdb_value_q;
    cdb_rdst_d  = cdb_rdst_q;
    ptr_d       = ptr_q;
    if (!Stall && found) begin
      grant_d[win] = 1'b1;
      cdb_valid_d  = 1'b1;
      cdb_tag_d    = Tag_in[int'(win)*TAG_W +: TAG_W];
      cdb_value_d  = Value_in[int'(win)*DATA_W +: DATA_W];
      cdb_rdst_d   = Rdst_in[int'(win)*3 +: 3];
      if (win == PTR_W'(N_REQ - 1))
        ptr_d = '0;
      else
        ptr_d = win + 1'b1;
    end
  end

  // Registered CDB outputs and pointer; reset discards any pending grant.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      grant_q     <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
      cdb_rdst_q  <= '0;
      tag_error_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      grant_q     <= grant_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_value_q <= cdb_value_d;
      cdb_rdst_q  <= cdb_rdst_d;
      tag_error_q <= tag_error_d;
      ptr_q       <= ptr_d;
    end
  end

  assign Grant     = grant_q;
  assign Cdb_valid = cdb_valid_q;
  assign Cdb_tag   = cdb_tag_q;
  assign Cdb_value = cdb_value_q;
  assign Cdb_rdst  = cdb_rdst_q;
  assign Tag_error = tag_error_q;

endmodule
